// File: rtl/acos_solver.sv
// rtl/acos_solver.sv - bit-serial arccos by successive approximation over a Horner-series cosine
// Optional cos_out result port is enabled by defining ACOS_COSOUT_EN.
module acos_solver #(
    parameter int XMAX  = 200,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [7:0]       y,
    output logic             busy,
    output logic             done,
`ifdef ACOS_COSOUT_EN
    output logic [9:0]       cos_out,
`endif
    output logic [NBITS+1:0] x
);

    localparam int BW = $clog2(NBITS);
    localparam logic [NBITS-1:0] XMAX_C = NBITS'(XMAX);

    typedef enum logic [2:0] {IDLE, SQUARE, MULZ, MULC, CMP, FIN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       y_q, y_d;
    logic [NBITS-1:0] angle_q, angle_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [15:0]      z_q, z_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      p_q, p_d;
    logic [1:0]       k_q, k_d;
    logic [NBITS+1:0] x_q, x_d;
`ifdef ACOS_COSOUT_EN
    logic [8:0]       cos_q, cos_d;
`endif

    logic [NBITS-1:0] trial;
    logic [15:0]      coef;
    logic [15:0]      mul_a, mul_b;
    logic [31:0]      mul_prod;
    logic [16:0]      prod_sh;
    logic             accept;

    // Shared multiplier operand selection, coefficient ROM and trial comparison
    always_comb begin
        trial = angle_q | (NBITS'(1) << bit_q);
        case (k_q)
            2'd0:    coef = 16'd1170;
            2'd1:    coef = 16'd2184;
            2'd2:    coef = 16'd5461;
            default: coef = 16'd32768;
        endcase
        case (state_q)
            SQUARE: begin mul_a = 16'(trial); mul_b = 16'(trial); end
            MULZ:   begin mul_a = z_q;        mul_b = acc_q;      end
            MULC:   begin mul_a = coef;       mul_b = p_q;        end
            default: begin mul_a = '0;        mul_b = '0;         end
        endcase
        mul_prod = {16'b0, mul_a} * {16'b0, mul_b};
        prod_sh  = 17'(mul_prod >> 15);
        // Out-of-range trials still run the full evaluation so latency never varies
        accept   = (trial <= XMAX_C) && (acc_q[15:7] >= {1'b0, y_q});
    end

    // Next-state and datapath updates for the search sequencer
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        angle_d = angle_q;
        bit_d   = bit_q;
        z_d     = z_q;
        acc_d   = acc_q;
        p_d     = p_q;
        k_d     = k_q;
        x_d     = x_q;
`ifdef ACOS_COSOUT_EN
        cos_d   = cos_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    y_d     = y;
                    angle_d = '0;
                    bit_d   = BW'(NBITS - 1);
`ifdef ACOS_COSOUT_EN
                    cos_d   = 9'd256;
`endif
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                z_d     = mul_prod[15:0];
                acc_d   = 16'd32768;
                k_d     = 2'd0;
                state_d = MULZ;
            end
            MULZ: begin
                p_d     = prod_sh[15:0];
                state_d = MULC;
            end
            MULC: begin
                acc_d = (prod_sh > 17'd32768) ? 16'd0 : 16'(17'd32768 - prod_sh);
                if (k_q != 2'd3) begin
                    k_d     = k_q + 2'd1;
                    state_d = MULZ;
                end else begin
                    state_d = CMP;
                end
            end
            CMP: begin
                if (accept) begin
                    angle_d = trial;
`ifdef ACOS_COSOUT_EN
                    cos_d   = acc_q[15:7];
`endif
                end
                if (bit_q != '0) begin
                    bit_d   = bit_q - BW'(1);
                    state_d = SQUARE;
                end else begin
                    // Result is registered here so it is already valid during FIN
                    x_d     = {2'b00, angle_d};
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            y_q     <= '0;
            angle_q <= '0;
            bit_q   <= '0;
            z_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
`ifdef ACOS_COSOUT_EN
            cos_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            angle_q <= angle_d;
            bit_q   <= bit_d;
            z_q     <= z_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            k_q     <= k_d;
            x_q     <= x_d;
`ifdef ACOS_COSOUT_EN
            cos_q   <= cos_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);
    assign x    = x_q;
`ifdef ACOS_COSOUT_EN
    assign cos_out = {1'b0, cos_q};
`endif

endmodule

// File: tb/tb_acos_solver.sv
// tb/tb_acos_solver.sv - scoreboard bench for acos_solver (directed vectors plus full y sweep)
module tb_acos_solver;

    localparam int XMAX = 200;
    localparam int LAT  = 81;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic [9:0] x;
`ifdef ACOS_COSOUT_EN
    logic [9:0] cos_out;
`endif

    acos_solver dut (
        .clk     (clk),
        .res     (res),
        .start   (start),
        .y       (y),
        .busy    (busy),
        .done    (done),
`ifdef ACOS_COSOUT_EN
        .cos_out (cos_out),
`endif
        .x       (x)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    ex;
        int    ec;
        int    edge_c;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_done = -10;

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    // Bit-exact reference cosine, Q1.8
    function automatic int cosq(input int t);
        longint z, acc, p, s;
        longint c [4];
        c   = '{1170, 2184, 5461, 32768};
        z   = longint'(t) * longint'(t);
        acc = 32768;
        for (int k = 0; k < 4; k++) begin
            p   = (z * acc) >> 15;
            s   = (c[k] * p) >> 15;
            acc = (s > 32768) ? 0 : 32768 - s;
        end
        return int'(acc >> 7);
    endfunction

    // Exhaustive search: largest legal angle whose cosine still reaches y
    function automatic int gold_x(input int yv);
        int best = 0;
        for (int a = 0; a <= XMAX; a++)
            if (cosq(a) >= yv) best = a;
        return best;
    endfunction

    function automatic int gold_cos(input int xv);
        return (xv == 0) ? 256 : cosq(xv);
    endfunction

    // Monitor: busy window, single-cycle done, result and latency against the scoreboard
    always @(negedge clk) begin
        if (!res) begin
            if (cyc == last_done + 1) begin
                check("done_single", int'(done), 0);
                check("busy_fall", int'(busy), 0);
            end
            if (sb.size() > 0 && cyc >= sb[0].edge_c && cyc - sb[0].edge_c < LAT)
                check("busy_high", int'(busy), 1);
            if (done) begin
                last_done = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.nm, "_x"}, int'(x), e.ex);
                    check({e.nm, "_lat"}, cyc - e.edge_c + 1, LAT);
`ifdef ACOS_COSOUT_EN
                    check({e.nm, "_cos"}, int'(cos_out), e.ec);
`endif
                end
            end
        end
    end

    task automatic issue(input int yv, input int ex, input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        y     = 8'(yv);
        @(posedge clk);
        #1;
        e.ex = ex; e.ec = ec; e.edge_c = cyc; e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        int   g10;
        res = 1'b1; start = 1'b0; y = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_x", int'(x), 0);
`ifdef ACOS_COSOUT_EN
        check("reset_cos", int'(cos_out), 0);
`endif
        res = 1'b0;

        issue(128, 134, 128, "y128");
        wait_idle();

        // Abort mid-search: outputs return to reset values and no done appears
        @(negedge clk);
        start = 1'b1; y = 8'd128;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_x", int'(x), 0);
        res = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_x", int'(x), 0);

        issue(128, 134, 128, "y128_again");
        wait_idle();
        issue(200, 86, gold_cos(86), "y200");
        wait_idle();
        issue(255, 11, gold_cos(11), "y255");
        wait_idle();
        issue(0, 200, gold_cos(200), "y0_xmax");
        wait_idle();

        // start held through a run, y changed mid-search, automatic back-to-back restart
        g10 = gold_x(10);
        @(negedge clk);
        start = 1'b1; y = 8'd128;
        @(posedge clk);
        #1;
        e1.ex = 134; e1.ec = 128; e1.edge_c = cyc; e1.nm = "held_y128";
        e2.ex = g10; e2.ec = gold_cos(g10); e2.edge_c = cyc + LAT + 1; e2.nm = "held_y10";
        sb.push_back(e1);
        sb.push_back(e2);
        repeat (20) @(negedge clk);
        y = 8'd10;
        while (cyc < e2.edge_c) @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int v = 0; v < 256; v++) begin
            int gx;
            gx = gold_x(v);
            issue(v, gx, gold_cos(gx), $sformatf("sweep%0d", v));
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
